io_arbiter: RTL and testbench

Shares the single 16-bit io port (addr / data / write / data_out) between NREQ bus masters, e.g. the core's pst/pld path and a debug/DMA loader. Uses round-robin arbitration and a req/ack handshake. Runs exactly one io transaction at a time and drives the io port directly.

---
 rtl/io_arb_pkg.sv | 19 +
 rtl/io_arbiter_rr_pick.sv | 29 ++
 rtl/io_arbiter.sv | 140 ++++++++++++++
 tb/tb_io_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_arb_pkg.sv
// Shared types and widths for the io port arbiter and its round-robin picker.
package io_arb_pkg;

    typedef enum logic [1:0] {
        ArbIdle,
        ArbAccess,
        ArbDone
    } ArbState;

    localparam int unsigned IO_ADDR_W = 16;
    localparam int unsigned IO_DATA_W = 16;
    localparam int unsigned WAIT_W    = 4;

    // Width of the rotation pointer / winner index for a given requester count.
    function automatic int unsigned arb_idx_w(input int unsigned nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/io_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward from ptr with wrap.
module rr_pick
    import io_arb_pkg::*;
#(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned IDX_W = arb_idx_w(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = IDX_W'((32'(ptr) + i) % NREQ);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/io_arbiter.sv
// Round-robin arbiter sharing one 16-bit io port between NREQ masters via req/ack.
// Optional IO_ARB_LOCK_EN adds a lock input that keeps the grant on the current winner.
module io_arbiter
    import io_arb_pkg::*;
#(
    parameter int unsigned NREQ        = 2,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      async_rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ-1:0]           we,
    input  logic [NREQ*IO_ADDR_W-1:0] addr,
    input  logic [NREQ*IO_DATA_W-1:0] wdata,
`ifdef IO_ARB_LOCK_EN
    input  logic [NREQ-1:0]           lock,
`endif
    output logic [NREQ-1:0]           ack,
    output logic [IO_DATA_W-1:0]      rdata,
    output logic                      busy,
    output logic [IO_ADDR_W-1:0]      io_addr,
    output logic [IO_DATA_W-1:0]      io_data,
    output logic                      io_write,
    input  logic [IO_DATA_W-1:0]      io_data_out
);

    localparam int unsigned IDX_W = arb_idx_w(NREQ);

    ArbState              state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     win_q, win_d;
    logic                 we_q, we_d;
    logic [IO_ADDR_W-1:0] addr_q, addr_d;
    logic [IO_DATA_W-1:0] wdata_q, wdata_d;
    logic [WAIT_W-1:0]    cnt_q, cnt_d;
    logic [IO_DATA_W-1:0] rd_q, rd_d;

    logic [IO_ADDR_W-1:0] addr_a  [NREQ];
    logic [IO_DATA_W-1:0] wdata_a [NREQ];
    logic                 pick_any;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     next_ptr;
    logic                 hold_ptr;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_a[g]  = addr[g*IO_ADDR_W +: IO_ADDR_W];
        assign wdata_a[g] = wdata[g*IO_DATA_W +: IO_DATA_W];
    end

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign next_ptr = (win_q == IDX_W'(NREQ - 1)) ? '0 : win_q + IDX_W'(1);

`ifdef IO_ARB_LOCK_EN
    assign hold_ptr = lock[win_q];
`else
    assign hold_ptr = 1'b0;
`endif

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state_q <= ArbIdle;
            ptr_q   <= '0;
            win_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        unique case (state_q)
            ArbIdle: begin
                if (pick_any) begin
                    win_d   = pick_idx;
                    we_d    = we[pick_idx];
                    addr_d  = addr_a[pick_idx];
                    wdata_d = wdata_a[pick_idx];
                    cnt_d   = WAIT_W'(WAIT_CYCLES);
                    state_d = ArbAccess;
                end
            end
            ArbAccess: begin
                cnt_d = cnt_q - WAIT_W'(1);
                // Read data is captured on the final access edge, while the port is still driven.
                if (cnt_q == WAIT_W'(1)) begin
                    rd_d    = we_q ? '0 : io_data_out;
                    state_d = ArbDone;
                end
            end
            ArbDone: begin
                ptr_d   = hold_ptr ? win_q : next_ptr;
                state_d = ArbIdle;
            end
            default: state_d = ArbIdle;
        endcase
    end

    always_comb begin
        ack = '0;
        if (state_q == ArbDone) begin
            ack[win_q] = 1'b1;
        end
    end

    // io_write decodes straight from state so an async reset drops it immediately.
    assign io_write = (state_q == ArbAccess) && we_q;
    assign busy     = (state_q != ArbIdle);
    assign io_addr  = addr_q;
    assign io_data  = wdata_q;
    assign rdata    = (state_q == ArbDone) ? rd_q : '0;

endmodule

// File: tb/tb_io_arbiter.sv
// Self-checking bench for io_arbiter: vector table, directed corner cases, randomized model check.
`timescale 1ns/1ps
module tb_io_arbiter;

    localparam int W3 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [1:0]  req1, we1, ack1;
    logic [31:0] addr1, wdata1;
    logic [15:0] rdata1, io_addr1, io_data1, io_dout1;
    logic        busy1, io_write1;

    logic [1:0]  req3, we3, ack3;
    logic [31:0] addr3, wdata3;
    logic [15:0] rdata3, io_addr3, io_data3, io_dout3;
    logic        busy3, io_write3;

`ifdef IO_ARB_LOCK_EN
    logic [1:0] lock1, lock3;
`endif

    assign io_dout1 = io_addr1 ^ 16'h5A5A;
    assign io_dout3 = io_addr3 ^ 16'h5A5A;

    io_arbiter #(.NREQ(2), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .async_rst(rst), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
`ifdef IO_ARB_LOCK_EN
        .lock(lock1),
`endif
        .ack(ack1), .rdata(rdata1), .busy(busy1), .io_addr(io_addr1), .io_data(io_data1),
        .io_write(io_write1), .io_data_out(io_dout1)
    );

    io_arbiter #(.NREQ(2), .WAIT_CYCLES(W3)) u_w3 (
        .clk(clk), .async_rst(rst), .req(req3), .we(we3), .addr(addr3), .wdata(wdata3),
`ifdef IO_ARB_LOCK_EN
        .lock(lock3),
`endif
        .ack(ack3), .rdata(rdata3), .busy(busy3), .io_addr(io_addr3), .io_data(io_data3),
        .io_write(io_write3), .io_data_out(io_dout3)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int ack_idx(input logic [1:0] a);
        return (a == 2'b01) ? 0 : (a == 2'b10) ? 1 : 9;
    endfunction

    typedef struct {
        int          idx;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vt[4];
    int   seq_idx[$];
    int   seq_cyc[$];

    // Reference model state for the randomized run
    int          m_ptr, m_win, n, g, next_ok, d;
    logic        m_we;
    logic [15:0] m_addr, m_wdata;
    logic [1:0]  cur_req, cur_we;
    logic [31:0] cur_addr, cur_wdata;

    initial begin
        int wcount, bcount, ack_at, got;
        logic [1:0] ack_val;

        rst = 1'b1;
        req1 = '0; we1 = '0; addr1 = '0; wdata1 = '0;
        req3 = '0; we3 = '0; addr3 = '0; wdata3 = '0;
`ifdef IO_ARB_LOCK_EN
        lock1 = '0; lock3 = '0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_ack", ack1, 0);
        chk("rst_rdata", rdata1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_io_addr", io_addr1, 0);
        chk("rst_io_data", io_data1, 0);
        chk("rst_io_write", io_write1, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single transactions on the WAIT_CYCLES=1 instance
        vt[0] = '{1, 1'b1, 16'h0010, 16'hBEEF, 16'h0000};
        vt[1] = '{0, 1'b0, 16'h0003, 16'h1234, 16'h5A59};
        vt[2] = '{0, 1'b1, 16'hFFFF, 16'h0001, 16'h0000};
        vt[3] = '{1, 1'b0, 16'hA5A5, 16'h7777, 16'hFFFF};
        for (int v = 0; v < 4; v++) begin
            req1 = '0;
            we1  = 2'($urandom);
            addr1 = $urandom;
            wdata1 = $urandom;
            req1[vt[v].idx] = 1'b1;
            we1[vt[v].idx] = vt[v].we;
            addr1[16*vt[v].idx +: 16] = vt[v].addr;
            wdata1[16*vt[v].idx +: 16] = vt[v].wdata;
            @(negedge clk);
            chk("vec_busy", busy1, 1);
            chk("vec_io_write", io_write1, vt[v].we);
            chk("vec_io_addr", io_addr1, vt[v].addr);
            chk("vec_io_data", io_data1, vt[v].wdata);
            chk("vec_no_early_ack", ack1, 0);
            req1 = '0;
            addr1 = $urandom;
            wdata1 = $urandom;
            we1 = ~we1;
            @(negedge clk);
            chk("vec_ack", ack1, 32'(1) << vt[v].idx);
            chk("vec_done_write", io_write1, 0);
            chk("vec_rdata", rdata1, vt[v].exp_rdata);
            chk("vec_addr_hold", io_addr1, vt[v].addr);
            @(negedge clk);
            chk("vec_ack_clear", ack1, 0);
            chk("vec_idle", busy1, 0);
        end

        // Fairness: both requesters held from reset
        rst = 1'b1;
        req1 = 2'b11; we1 = 2'b11;
        addr1 = {16'h1111, 16'h0000};
        wdata1 = {16'hB1B1, 16'hA0A0};
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (ack1 != 2'b00) begin
                seq_idx.push_back(ack_idx(ack1));
                seq_cyc.push_back(c);
            end
        end
        chk("fair_count_ge4", 32'(seq_idx.size() >= 4), 1);
        if (seq_idx.size() >= 4) begin
            for (int k = 0; k < 4; k++) chk("fair_order", seq_idx[k], k % 2);
            chk("fair_first_ack", seq_cyc[0], 2);
            for (int k = 1; k < 4; k++) chk("fair_spacing", seq_cyc[k] - seq_cyc[k-1], 3);
        end
        req1 = '0;
        repeat (4) @(negedge clk);

        // WAIT_CYCLES=3 single write by requester 0
        req3 = 2'b01; we3 = 2'b01;
        addr3 = {16'h0000, 16'h0300};
        wdata3 = {16'h0000, 16'hC0DE};
        wcount = 0; bcount = 0; ack_at = 0; ack_val = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (io_write3) begin
                wcount++;
                chk("w3_io_addr", io_addr3, 16'h0300);
                chk("w3_io_data", io_data3, 16'hC0DE);
            end
            if (busy3) bcount++;
            if (ack3 != 2'b00 && ack_at == 0) begin
                ack_at = k;
                ack_val = ack3;
                req3 = '0;
            end
        end
        chk("w3_write_cycles", wcount, 3);
        chk("w3_busy_cycles", bcount, 4);
        chk("w3_ack_latency", ack_at, 4);
        chk("w3_ack_bit", ack_val, 2'b01);

        // Reset in flight: pointer now favours requester 1; reset must bring it back to 0
        req3 = 2'b10; we3 = 2'b10;
        addr3 = {16'h0444, 16'h0000};
        @(negedge clk);
        @(negedge clk);
        chk("rif_write_before", io_write3, 1);
        #2 rst = 1'b1;
        #1;
        chk("rif_write_dropped", io_write3, 0);
        chk("rif_busy_dropped", busy3, 0);
        req3 = 2'b11; we3 = 2'b00;
        addr3 = {16'h0444, 16'h0555};
        got = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (ack3 != 2'b00) got++;
        end
        chk("rif_no_ack", got, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rif_regrant_addr", io_addr3, 16'h0555);
        chk("rif_regrant_busy", busy3, 1);
        got = 0;
        for (int k = 0; k < 6 && got == 0; k++) begin
            @(negedge clk);
            if (ack3 != 2'b00) begin
                got = 1;
                chk("rif_ack", ack3, 2'b01);
                chk("rif_rdata", rdata3, 16'h5F0F);
                req3 = '0;
            end
        end
        chk("rif_ack_seen", got, 1);
        repeat (5) @(negedge clk);

`ifdef IO_ARB_LOCK_EN
        rst = 1'b1;
        seq_idx.delete();
        lock1 = 2'b01;
        req1 = 2'b11; we1 = 2'b11;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 30 && seq_idx.size() < 4; c++) begin
            @(negedge clk);
            if (ack1 != 2'b00) begin
                seq_idx.push_back(ack_idx(ack1));
                if (seq_idx.size() == 3) lock1 = 2'b00;
            end
        end
        chk("lock_count", seq_idx.size(), 4);
        if (seq_idx.size() == 4) begin
            for (int k = 0; k < 3; k++) chk("lock_hold", seq_idx[k], 0);
            chk("lock_release", seq_idx[3], 1);
        end
        req1 = '0;
        repeat (4) @(negedge clk);
`endif

        // Randomized run on the WAIT_CYCLES=3 instance against a transaction-level model
        rst = 1'b1;
        req3 = '0; we3 = '0; addr3 = '0; wdata3 = '0;
        @(negedge clk);
        rst = 1'b0;
        m_ptr = 0; m_win = 0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
        n = 0; g = -1000; next_ok = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk);
            cur_req = req3; cur_we = we3; cur_addr = addr3; cur_wdata = wdata3;
            if (n >= next_ok && cur_req != 2'b00) begin
                m_win = cur_req[m_ptr] ? m_ptr : (m_ptr + 1) % 2;
                m_we = cur_we[m_win];
                m_addr = cur_addr[16*m_win +: 16];
                m_wdata = cur_wdata[16*m_win +: 16];
                g = n;
                next_ok = n + W3 + 2;
                m_ptr = (m_win + 1) % 2;
            end
            @(negedge clk);
            d = n - g;
            chk("rnd_busy", busy3, 32'(d >= 0 && d <= W3));
            chk("rnd_io_write", io_write3, 32'(m_we && d >= 0 && d < W3));
            chk("rnd_ack", ack3, (d == W3) ? (32'(1) << m_win) : 32'(0));
            chk("rnd_rdata", rdata3, (d == W3 && !m_we) ? 32'(m_addr ^ 16'h5A5A) : 32'(0));
            chk("rnd_io_addr", io_addr3, m_addr);
            chk("rnd_io_data", io_data3, m_wdata);
            for (int i = 0; i < 2; i++) begin
                if (ack3[i]) begin
                    req3[i] = ($urandom_range(1, 0) == 1);
                    we3[i] = 1'($urandom);
                    addr3[16*i +: 16] = 16'($urandom);
                    wdata3[16*i +: 16] = 16'($urandom);
                end else if (!req3[i]) begin
                    if ($urandom_range(9, 0) < 3) begin
                        req3[i] = 1'b1;
                        we3[i] = 1'($urandom);
                        addr3[16*i +: 16] = 16'($urandom);
                        wdata3[16*i +: 16] = 16'($urandom);
                    end
                end else if ($urandom_range(3, 0) == 0) begin
                    we3[i] = 1'($urandom);
                    addr3[16*i +: 16] = 16'($urandom);
                    wdata3[16*i +: 16] = 16'($urandom);
                end
            end
            n++;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
